// File: rtl/status_monitor_if.sv
// AXI-Stream status channel: one instance per direction, master drives tdata/tvalid.
interface status_monitor_if #(
  parameter int unsigned WIDTH = 24
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/status_monitor.sv
// Status sink: buffers accepted status words in a FIFO drained over AXI-Stream,
// with saturating beat/drop counters and sticky error/overflow flags.
module status_monitor #(
  parameter int unsigned      WIDTH        = 24,
  parameter int unsigned      DEPTH        = 8,
  parameter int unsigned      CNT_W        = 16,
  parameter logic [WIDTH-1:0] ERR_MASK     = '0,
  parameter bit               BACKPRESSURE = 1'b0
) (
  input  logic                    aclk,
  input  logic                    areset,
  status_monitor_if.slave         s_axis_status,
  status_monitor_if.master        m_axis_status,
  input  logic                    clear,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        beat_count,
  output logic [CNT_W-1:0]        drop_count,
  output logic                    err_sticky,
  output logic                    ovf_sticky
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             ready;
  logic             push;
  logic             pop;
  logic             drop;
  logic             err_hit;

  // Ready depends only on registered level (and reset), never on the drain side.
  assign ready = BACKPRESSURE ? ~(full | areset) : 1'b1;

  always_comb begin
    full    = (level == LW'(DEPTH));
    push    = s_axis_status.tvalid & ready & ~full;
    pop     = m_axis_status.tvalid & m_axis_status.tready;
    drop    = !BACKPRESSURE & s_axis_status.tvalid & full;
    err_hit = push & (|(s_axis_status.tdata & ERR_MASK));
  end

  assign s_axis_status.tready = ready;
  assign m_axis_status.tdata  = mem[rd_ptr];
  assign m_axis_status.tvalid = (level != '0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      beat_count <= '0;
      drop_count <= '0;
      err_sticky <= 1'b0;
      ovf_sticky <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_axis_status.tdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);

      // Clear restarts accumulation from this cycle's events rather than zeroing.
      if (clear) begin
        beat_count <= CNT_W'(push);
        drop_count <= CNT_W'(drop);
        err_sticky <= err_hit;
        ovf_sticky <= drop;
      end else begin
        if (push && beat_count != '1) beat_count <= beat_count + CNT_W'(1);
        if (drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        err_sticky <= err_sticky | err_hit;
        ovf_sticky <= ovf_sticky | drop;
      end
    end
  end
endmodule
